// File: rtl/cpu_input_port.sv
// cpu_input_port: producer end of the CPU input handshake (in/control/status).
// Words pushed via wr_en/wr_data are queued in a DEPTH-word FIFO. The head
// word is presented on `in` with `control` high, and popped when the CPU
// strobes `status`.
// Optional build macro CPU_INPUT_PORT_STICKY_EN: when the FIFO drains, `in`
// and `control` hold the last presented word instead of clearing.
module cpu_input_port #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [15:0]   wr_data,
  input  logic          wr_en,
  input  logic          status,
  output logic [15:0]   in,
  output logic          control,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overflow
);

  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_LAST = (AW+1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_AVAIL,
    S_FULL
  } state_t;

  state_t        state, state_d;
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, rd_next, wr_next;
  logic [AW:0]   count_d;
  logic [15:0]   head, in_d;
  logic          control_d;
  logic          pop, push, drop;

  // Handshake decode, pointer/count/state update and next presented word.
  always_comb begin
    pop     = status && control && (state != S_EMPTY);
    push    = wr_en && ((state != S_FULL) || pop);
    drop    = wr_en && !push;
    rd_next = pop  ? rd_ptr + AW'(1) : rd_ptr;
    wr_next = push ? wr_ptr + AW'(1) : wr_ptr;
    count_d = count;
    state_d = state;
    if (push && !pop)
      count_d = count + CNT_ONE;
    else if (pop && !push)
      count_d = count - CNT_ONE;

    case (state)
      S_EMPTY: if (push) state_d = S_AVAIL;
      S_AVAIL: begin
        if (push && !pop && (count == CNT_LAST))
          state_d = S_FULL;
        else if (pop && !push && (count == CNT_ONE))
          state_d = S_EMPTY;
      end
      S_FULL:  if (pop && !push) state_d = S_AVAIL;
      default: state_d = S_EMPTY;
    endcase

    // The slot being written this edge can become the new head (push into
    // an empty FIFO, or push+pop with one word held): bypass the array.
    head = (push && (wr_ptr == rd_next)) ? wr_data : mem[rd_next];

`ifdef CPU_INPUT_PORT_STICKY_EN
    in_d      = (count_d != '0) ? head : in;
    control_d = (count_d != '0) || control;
`else
    in_d      = (count_d != '0) ? head : '0;
    control_d = (count_d != '0);
`endif
  end

  // Control state, pointers and registered CPU-facing outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_EMPTY;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      in       <= '0;
      control  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_d;
      rd_ptr   <= rd_next;
      wr_ptr   <= wr_next;
      count    <= count_d;
      in       <= in_d;
      control  <= control_d;
      if (drop)
        overflow <= 1'b1;
    end
  end

  // Word storage; contents are only read once written, so no reset needed.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= wr_data;
  end

  assign full = (state == S_FULL);

endmodule

// File: tb/tb_cpu_input_port.sv
// Self-checking bench for cpu_input_port: directed steps with a queue
// scoreboard of accepted words.
module tb_cpu_input_port;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   wr_data;
  logic          wr_en;
  logic          status;
  logic [15:0]   in;
  logic          control;
  logic          full;
  logic [AW:0]   count;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  logic [15:0] q [$];
  logic        ovf_m;
  logic [15:0] idle_in_m;
  logic        idle_ctl_m;

  cpu_input_port #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .status   (status),
    .in       (in),
    .control  (control),
    .full     (full),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check16(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    logic [15:0] ei;
    logic        ec;
    if (q.size() != 0) begin
      ei = q[0];
      ec = 1'b1;
    end else begin
      ei = idle_in_m;
      ec = idle_ctl_m;
    end
    check16({ctx, " in"}, in, ei);
    check16({ctx, " control"}, 16'(control), 16'(ec));
    check16({ctx, " count"}, 16'(count), 16'(q.size()));
    check16({ctx, " full"}, 16'(full), 16'(q.size() == DEPTH));
    check16({ctx, " overflow"}, 16'(overflow), 16'(ovf_m));
  endtask

  // Called at a falling edge; drives one cycle and checks after the next rise.
  task automatic step(input string ctx, input logic w, input logic [15:0] d, input logic s);
    logic        pop_m, push_m;
    logic [15:0] popped;
    wr_en   = w;
    wr_data = d;
    status  = s;
    pop_m   = s && (q.size() != 0);
    push_m  = w && ((q.size() < DEPTH) || pop_m);
    popped  = '0;
    if (pop_m) begin
      popped = q[0];
      check16({ctx, " consumed"}, in, popped);
    end
    @(posedge clk);
    if (pop_m) void'(q.pop_front());
    if (push_m) q.push_back(d);
    if (w && !push_m) ovf_m = 1'b1;
`ifdef CPU_INPUT_PORT_STICKY_EN
    if (pop_m && (q.size() == 0)) begin
      idle_in_m  = popped;
      idle_ctl_m = 1'b1;
    end
`endif
    @(negedge clk);
    wr_en  = 1'b0;
    status = 1'b0;
    check_all(ctx);
  endtask

  task automatic do_reset(input string ctx);
    rst_n   = 1'b0;
    wr_en   = 1'b1;
    wr_data = 16'hFFFF;
    status  = 1'b0;
    q.delete();
    ovf_m      = 1'b0;
    idle_in_m  = '0;
    idle_ctl_m = 1'b0;
    #1;
    check_all({ctx, " async"});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_all({ctx, " held"});
    end
    wr_en = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check_all({ctx, " released"});
  endtask

  logic [15:0] wrap_data [5] = '{16'h0008, 16'h0009, 16'h0003, 16'h0001, 16'h0002};

  initial begin
    do_reset("reset");

    // Single word in and out, then a status strobe with nothing presented.
    step("single push", 1'b1, 16'h0008, 1'b0);
    step("single idle", 1'b0, 16'h0000, 1'b0);
    step("single pop",  1'b0, 16'h0000, 1'b1);
    step("void pop",    1'b0, 16'h0000, 1'b1);

    // Ordering across pointer wrap, popping every third cycle.
    for (int i = 0; i < 15; i++)
      step("wrap", i < 5, (i < 5) ? wrap_data[i] : 16'h0000, (i % 3) == 2);
    for (int k = 0; k < 10 && q.size() != 0; k++)
      step("wrap drain", 1'b0, 16'h0000, 1'b1);

    // Fill past capacity; the fifth word must be dropped.
    for (int v = 1; v <= 5; v++)
      step("fill", 1'b1, 16'(v), 1'b0);
    for (int k = 0; k < 6; k++)
      step("overflow drain", 1'b0, 16'h0000, 1'b1);

    do_reset("reset after overflow");

    // Push and pop together while full.
    for (int v = 1; v <= 4; v++)
      step("refill", 1'b1, 16'(v), 1'b0);
    step("push+pop full", 1'b1, 16'h00AA, 1'b1);
    for (int k = 0; k < 5; k++)
      step("full drain", 1'b0, 16'h0000, 1'b1);

    // Reset while words are buffered discards them.
    step("pre-reset push", 1'b1, 16'h0005, 1'b0);
    step("pre-reset push", 1'b1, 16'h0006, 1'b0);
    #2;
    do_reset("mid-op reset");
    step("post-reset push", 1'b1, 16'h0007, 1'b0);
    step("post-reset pop",  1'b0, 16'h0000, 1'b1);

`ifdef CPU_INPUT_PORT_STICKY_EN
    do_reset("sticky reset");
    step("sticky push",  1'b1, 16'h0003, 1'b0);
    step("sticky pop",   1'b0, 16'h0000, 1'b1);
    step("sticky repop", 1'b0, 16'h0000, 1'b1);
    step("sticky push2", 1'b1, 16'h0009, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
